seq_step_monitor: RTL and testbench
===================================

# seq_step_monitor

Parametrised input-sequence monitor for the FSM test benches: watches an NUM_IN-bit stimulus bus and checks that channels reach a programmed list of levels in order. The list is a run-time-programmable step table of up to DEPTH entries. Optional strict ordering and per-step timeout make it report illegal or stalled sequences, not just stall. It sits beside the device under test and reports done/error status and the failing step to the test controller.

## Interface
- NUM_IN, 2: width of monitored bus; CW = max(1, clog2(NUM_IN)).
- DEPTH, 16: step-table entries; SW = clog2(DEPTH+1).
- TO_W, 16: timeout counter width.

- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- prog_we  in  1  step-table write strobe.
- prog_addr  in  clog2(DEPTH)  entry written.
- prog_chan  in  CW  channel index of entry.
- prog_val  in  1  required level of entry.
- num_steps  in  SW  steps to run; latched at start.
- strict  in  1  enable unexpected-change checking; latched at start.
- timeout_limit  in  TO_W  max cycles per step; 0 disables; latched at start.
- start  in  1  begin a run.
- in_bus  in  NUM_IN  monitored stimulus.
- busy  out  1  run in progress.
- done  out  1  sticky, all steps matched.
- error  out  1  sticky, run failed.
- err_code  out  2  0 none, 1 unexpected change, 2 timeout.
- step_idx  out  SW  index of step being waited on / reached.
- fail_step  out  SW  step_idx captured at error.

## Operation
- States: IDLE, RUN, DONE, ERROR.
- Reset: state IDLE, busy=0, done=0, error=0, err_code=0, step_idx=0, fail_step=0, timeout counter 0, in_q/in_q_prev=0.
- Step table is not cleared by reset. It must be programmed before use.
- Table writes are accepted in IDLE, DONE and ERROR. Writes are ignored while busy. prog_addr >= DEPTH is ignored.
- in_bus is registered every cycle into in_q, and in_q into in_q_prev. All checks use in_q.
- IDLE/DONE/ERROR + start: latch num_steps, strict and timeout_limit. Clear done, error, err_code, step_idx and the counter, then go to RUN.
  - num_steps > DEPTH is clamped to DEPTH.
  - num_steps = 0 goes directly to DONE instead.
- start while in RUN is ignored.
- RUN, each cycle, with current entry E = table[step_idx]:
  - viol = strict and ((in_q ^ in_q_prev) has any bit set other than bit E.chan).
  - match = (in_q[E.chan] == E.val). This is a level check: a step already satisfied at entry completes on its first evaluated cycle.
  - Priority: viol > match > timeout.
  - viol: go to ERROR, err_code=1, fail_step=step_idx.
  - match: step_idx+1 and counter cleared. If step_idx == num_steps-1, go to DONE (done=1; step_idx ends at num_steps).
  - Otherwise the counter increments. If timeout_limit != 0 and counter+1 == timeout_limit, go to ERROR, err_code=2, fail_step=step_idx.
- At most one step advances per cycle.
- Simultaneous change of the expected channel and any other channel in strict mode is an error.
- DONE/ERROR hold all outputs until start or reset.
- Reset mid-run aborts to IDLE with outputs at reset values. The table is kept.

## Timing
- start sampled at edge T: busy=1 after edge T.
- in_bus change captured at edge T appears in in_q after T and is evaluated in that cycle. step_idx/done/error update at edge T+1.
  - Stimulus-to-status latency: 2 clocks.
- busy deasserts on the same edge that done or error asserts.
- Timeout with limit L: error asserts at the L-th evaluated RUN cycle of a step with no match.

## Test plan
- AND-gate sequence: program 11 steps (i1↑, i2↑, i1↓, i2↓, i1↑, i2↑, i1↓, i2↓, i2↑, i1↑, i1↓ as chan/val pairs), strict=1, timeout 0, drive each toggle 3 cycles apart. Expected: step_idx counts 0..11, done=1, error=0, err_code=0.
- Strict violation: same table, raise i2 while step 0 is waiting on i1=1. Expected: error=1, err_code=1, fail_step=0, busy=0 two cycles after the change.
- Timeout: timeout_limit=5, never drive step 2. Expected: err_code=2, fail_step=2, error asserted exactly 5 evaluated cycles after step 1 matched.
- Boundaries:
  - num_steps=0: done=1 one cycle after start.
  - num_steps=DEPTH+3: clamped, step_idx ends at DEPTH.
  - Table write while busy: table unchanged; a rerun behaves as before.
- Reset mid-run at step 4: all outputs return to reset values. A subsequent start with no reprogramming rerun passes (table retained).
- NUM_IN=4, DEPTH=8 build: 8-step sequence on channels 3,0,2,1; strict=0 with noise toggles on other channels. Expected: done=1.

Source files
------------

// File: rtl/seq_step_monitor_if.sv
// seq_step_monitor_if
//   Bundles the programming, run-control, stimulus and status signals of
//   seq_step_monitor.
//   master : test controller side (drives table/program/start/in_bus, reads status)
//   slave  : monitor side (reads controls and in_bus, drives status)
//   Widths: CW = channel index, AW = table address, SW = step count/index.
interface seq_step_monitor_if #(
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 16,
    parameter int TO_W   = 16
);
    localparam int CW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DEPTH + 1);

    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [CW-1:0]     prog_chan;
    logic              prog_val;
    logic [SW-1:0]     num_steps;
    logic              strict;
    logic [TO_W-1:0]   timeout_limit;
    logic              start;
    logic [NUM_IN-1:0] in_bus;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [SW-1:0]     step_idx;
    logic [SW-1:0]     fail_step;

    modport master (
        output prog_we, prog_addr, prog_chan, prog_val,
        output num_steps, strict, timeout_limit, start, in_bus,
        input  busy, done, error, err_code, step_idx, fail_step
    );

    modport slave (
        input  prog_we, prog_addr, prog_chan, prog_val,
        input  num_steps, strict, timeout_limit, start, in_bus,
        output busy, done, error, err_code, step_idx, fail_step
    );
endinterface

// File: rtl/seq_step_monitor.sv
// seq_step_monitor
//   Watches an NUM_IN-bit stimulus bus and checks that channels reach the
//   levels listed in a run-time programmed step table, in order. Optional
//   strict mode flags changes on channels other than the one being waited
//   on; an optional per-step timeout flags stalled sequences.
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-high
//     sif   : seq_step_monitor_if.slave (table programming, run control,
//             in_bus, and busy/done/error/err_code/step_idx/fail_step)
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | after reset, waiting for start; table writable
//   S_RUN   | stepping through the table; table writes ignored
//   S_DONE  | all steps matched; status held until start/reset
//   S_ERROR | violation or timeout; status held until start/reset
module seq_step_monitor #(
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 16,
    parameter int TO_W   = 16
) (
    input  logic clk,
    input  logic reset,
    seq_step_monitor_if.slave sif
);
    localparam int CW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Step table: deliberately not reset so a reset mid-run keeps it.
    logic [CW-1:0]     r_tab_chan [DEPTH];
    logic              r_tab_val  [DEPTH];

    logic [NUM_IN-1:0] r_in_q;
    logic [NUM_IN-1:0] r_in_q_prev;
    logic [SW-1:0]     r_num_steps;
    logic              r_strict;
    logic [TO_W-1:0]   r_to_limit;
    logic [TO_W-1:0]   r_cnt;
    logic [SW-1:0]     r_step_idx;
    logic [SW-1:0]     r_fail_step;
    logic [1:0]        r_err_code;

    logic              w_tab_we;
    logic [SW-1:0]     w_num_clamped;
    logic [AW-1:0]     w_idx;
    logic [CW-1:0]     w_chan;
    logic              w_val;
    logic [NUM_IN-1:0] w_diff;
    logic [NUM_IN-1:0] w_sel;
    logic              w_viol;
    logic              w_match;
    logic              w_last;
    logic [TO_W-1:0]   w_cnt_inc;
    logic              w_to_hit;

    assign w_tab_we      = sif.prog_we && (r_state != S_RUN)
                           && (32'(sif.prog_addr) < 32'(DEPTH));
    assign w_num_clamped = (sif.num_steps > SW'(DEPTH)) ? SW'(DEPTH) : sif.num_steps;

    // step_idx < num_steps <= DEPTH whenever RUN evaluates, so the low bits address the table.
    assign w_idx   = r_step_idx[AW-1:0];
    assign w_chan  = r_tab_chan[w_idx];
    assign w_val   = r_tab_val[w_idx];

    // Any edge on a channel other than the awaited one is illegal in strict mode,
    // including a simultaneous change alongside the awaited channel.
    assign w_diff  = r_in_q ^ r_in_q_prev;
    assign w_sel   = NUM_IN'(1) << w_chan;
    assign w_viol  = r_strict && (|(w_diff & ~w_sel));
    assign w_match = (r_in_q[w_chan] == w_val);
    assign w_last  = ((r_step_idx + SW'(1)) == r_num_steps);

    assign w_cnt_inc = r_cnt + TO_W'(1);
    assign w_to_hit  = (r_to_limit != '0) && (w_cnt_inc == r_to_limit);

    always_ff @(posedge clk) begin
        if (w_tab_we) begin
            r_tab_chan[sif.prog_addr] <= sif.prog_chan;
            r_tab_val[sif.prog_addr]  <= sif.prog_val;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_viol) begin
                    w_state_nxt = S_ERROR;
                end else if (w_match) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end else if (w_to_hit) begin
                    w_state_nxt = S_ERROR;
                end
            end
            default: begin
                if (sif.start) begin
                    w_state_nxt = (w_num_clamped == '0) ? S_DONE : S_RUN;
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        sif.busy      = (r_state == S_RUN);
        sif.done      = (r_state == S_DONE);
        sif.error     = (r_state == S_ERROR);
        sif.err_code  = r_err_code;
        sif.step_idx  = r_step_idx;
        sif.fail_step = r_fail_step;
    end

    // Datapath: input pipeline, run parameters, step index, timeout counter, error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_q      <= '0;
            r_in_q_prev <= '0;
            r_num_steps <= '0;
            r_strict    <= 1'b0;
            r_to_limit  <= '0;
            r_cnt       <= '0;
            r_step_idx  <= '0;
            r_fail_step <= '0;
            r_err_code  <= 2'd0;
        end else begin
            r_in_q      <= sif.in_bus;
            r_in_q_prev <= r_in_q;
            if (r_state == S_RUN) begin
                if (w_viol) begin
                    r_err_code  <= 2'd1;
                    r_fail_step <= r_step_idx;
                end else if (w_match) begin
                    r_step_idx <= r_step_idx + SW'(1);
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                    if (w_to_hit) begin
                        r_err_code  <= 2'd2;
                        r_fail_step <= r_step_idx;
                    end
                end
            end else if (sif.start) begin
                r_num_steps <= w_num_clamped;
                r_strict    <= sif.strict;
                r_to_limit  <= sif.timeout_limit;
                r_cnt       <= '0;
                r_step_idx  <= '0;
                r_err_code  <= 2'd0;
            end
        end
    end
endmodule

// File: tb/tb_seq_step_monitor.sv
module tb_seq_step_monitor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_step_monitor_if #(.NUM_IN(2), .DEPTH(16), .TO_W(16)) ifa ();
    seq_step_monitor_if #(.NUM_IN(4), .DEPTH(8),  .TO_W(16)) ifb ();

    seq_step_monitor #(.NUM_IN(2), .DEPTH(16), .TO_W(16)) u_a (.clk(clk), .reset(reset), .sif(ifa));
    seq_step_monitor #(.NUM_IN(4), .DEPTH(8),  .TO_W(16)) u_b (.clk(clk), .reset(reset), .sif(ifb));

    // Generic stimulus, routed to whichever build is active.
    logic        act;
    logic        d_we, d_val, d_strict, d_start;
    logic [3:0]  d_addr;
    logic [1:0]  d_chan;
    logic [4:0]  d_num;
    logic [15:0] d_to;
    logic [3:0]  d_bus;

    assign ifa.prog_we       = !act && d_we;
    assign ifa.prog_addr     = d_addr;
    assign ifa.prog_chan     = d_chan[0];
    assign ifa.prog_val      = d_val;
    assign ifa.num_steps     = d_num;
    assign ifa.strict        = d_strict;
    assign ifa.timeout_limit = d_to;
    assign ifa.start         = !act && d_start;
    assign ifa.in_bus        = act ? 2'b00 : d_bus[1:0];

    assign ifb.prog_we       = act && d_we;
    assign ifb.prog_addr     = d_addr[2:0];
    assign ifb.prog_chan     = d_chan;
    assign ifb.prog_val      = d_val;
    assign ifb.num_steps     = d_num[3:0];
    assign ifb.strict        = d_strict;
    assign ifb.timeout_limit = d_to;
    assign ifb.start         = act && d_start;
    assign ifb.in_bus        = act ? d_bus : 4'b0000;

    logic       g_busy, g_done, g_error;
    logic [1:0] g_code;
    logic [4:0] g_idx, g_fail;
    always_comb begin
        g_busy  = act ? ifb.busy  : ifa.busy;
        g_done  = act ? ifb.done  : ifa.done;
        g_error = act ? ifb.error : ifa.error;
        g_code  = act ? ifb.err_code : ifa.err_code;
        g_idx   = act ? {1'b0, ifb.step_idx}  : ifa.step_idx;
        g_fail  = act ? {1'b0, ifb.fail_step} : ifa.fail_step;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%h expected=%h (busy,done,error,code[2],idx[5],fail[5])",
                     nm, $time, got, exp);
        end
    endtask

    function automatic logic [14:0] pk(int b, int d, int e, int c, int i, int f);
        return {b[0], d[0], e[0], c[1:0], i[4:0], f[4:0]};
    endfunction

    function automatic logic [14:0] got_status();
        return {g_busy, g_done, g_error, g_code, g_idx, g_fail};
    endfunction

    // Behavioural reference: tracks what the monitor has observed and what it has
    // concluded so far. "seen" is the stimulus the monitor has registered; a step is
    // judged on the latest two registered samples.
    int m_tchan [16];
    int m_tval  [16];
    bit m_busy, m_done, m_error;
    int m_code, m_idx, m_fail, m_n, m_limit, m_waited;
    bit m_strict;
    int m_seen, m_prev;

    initial begin
        forever begin
            int depth, bus_now, e, others;
            @(posedge clk);
            depth   = act ? 8 : 16;
            bus_now = act ? int'(d_bus) : int'(d_bus[1:0]);
            if (reset) begin
                m_busy = 0; m_done = 0; m_error = 0;
                m_code = 0; m_idx = 0; m_fail = 0; m_waited = 0;
                m_seen = 0; m_prev = 0;
            end else begin
                if (!m_busy && d_we && int'(d_addr) < depth) begin
                    m_tchan[d_addr] = int'(d_chan);
                    m_tval[d_addr]  = int'(d_val);
                end
                if (m_busy) begin
                    e      = m_tchan[m_idx];
                    others = (m_seen ^ m_prev) & ~(1 << e);
                    if (m_strict && others != 0) begin
                        m_busy = 0; m_error = 1; m_code = 1; m_fail = m_idx;
                    end else if (((m_seen >> e) & 1) == m_tval[m_idx]) begin
                        m_idx++;
                        m_waited = 0;
                        if (m_idx == m_n) begin
                            m_busy = 0; m_done = 1;
                        end
                    end else begin
                        m_waited++;
                        if (m_limit != 0 && m_waited == m_limit) begin
                            m_busy = 0; m_error = 1; m_code = 2; m_fail = m_idx;
                        end
                    end
                end else if (d_start) begin
                    m_n      = (int'(d_num) > depth) ? depth : int'(d_num);
                    m_strict = d_strict;
                    m_limit  = int'(d_to);
                    m_done = 0; m_error = 0; m_code = 0; m_idx = 0; m_waited = 0;
                    if (m_n == 0) m_done = 1;
                    else          m_busy = 1;
                end
                m_prev = m_seen;
                m_seen = bus_now;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_cycle", 32'(got_status()),
                    32'(pk(m_busy, m_done, m_error, m_code, m_idx, m_fail)));
            end
        end
    end

    // AND-gate sequence in entries 0..10, filler steps in 11..15.
    int tab_c [16] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0};
    int tab_v [16] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0};
    int b_c [8]    = '{3, 0, 2, 1, 3, 0, 2, 1};
    int b_v [8]    = '{1, 1, 1, 1, 0, 0, 0, 0};

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic prog(int a, int c, int v);
        d_we = 1'b1; d_addr = 4'(a); d_chan = 2'(c); d_val = v[0];
        cyc(1);
        d_we = 1'b0;
    endtask

    task automatic go(int n, int s, int to);
        d_num = 5'(n); d_strict = s[0]; d_to = 16'(to); d_start = 1'b1;
        cyc(1);
        d_start = 1'b0;
    endtask

    task automatic set_ch(int c, int v);
        d_bus[c] = v[0];
    endtask

    task automatic lit(string nm, int b, int d, int e, int c, int i, int f);
        chk(nm, 32'(got_status()), 32'(pk(b, d, e, c, i, f)));
    endtask

    task automatic and_steps();
        for (int i = 0; i < 11; i++) begin
            set_ch(tab_c[i], tab_v[i]);
            cyc(3);
        end
    endtask

    initial begin
        reset = 1'b1; act = 1'b0;
        d_we = 0; d_val = 0; d_strict = 0; d_start = 0;
        d_addr = 0; d_chan = 0; d_num = 0; d_to = 0; d_bus = 0;
        cyc(2);
        chk_en = 1'b1;
        lit("reset_state", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) prog(i, tab_c[i], tab_v[i]);

        // AND-gate sequence, strict, no timeout
        go(11, 1, 0);
        lit("busy_after_start", 1, 0, 0, 0, 0, 0);
        cyc(2);
        and_steps();
        lit("and_done", 0, 1, 0, 0, 11, 0);

        // strict violation: i2 rises while step 0 waits on i1
        d_bus = 4'b0000; cyc(3);
        go(11, 1, 0); cyc(2);
        set_ch(1, 1);
        cyc(1);
        lit("viol_latency_1", 1, 0, 0, 0, 0, 0);
        cyc(1);
        lit("viol_error", 0, 0, 1, 1, 0, 0);

        // timeout of 5 on step 2
        d_bus = 4'b0000; cyc(3);
        go(11, 1, 5); cyc(2);
        set_ch(0, 1); cyc(3);
        set_ch(1, 1);
        cyc(6);
        lit("timeout_not_yet", 1, 0, 0, 0, 2, 0);
        cyc(1);
        lit("timeout_error", 0, 0, 1, 2, 2, 2);

        // zero steps: done right after start, fail_step kept from last error
        go(0, 1, 0);
        lit("zero_steps", 0, 1, 0, 0, 0, 2);

        // clamp: 19 requested, full 16-entry table runs
        for (int i = 11; i < 16; i++) prog(i, tab_c[i], tab_v[i]);
        d_bus = 4'b0000; cyc(2);
        go(19, 0, 0); cyc(1);
        for (int i = 0; i < 16; i++) begin
            set_ch(tab_c[i], tab_v[i]);
            cyc(3);
        end
        lit("clamp_depth", 0, 1, 0, 0, 16, 2);

        // writes while busy are ignored
        d_bus = 4'b0000; cyc(2);
        go(11, 1, 0);
        prog(0, 1, 1);
        prog(1, 0, 0);
        and_steps();
        lit("busy_write_ignored", 0, 1, 0, 0, 11, 2);

        // reset mid-run at step 4, then rerun without reprogramming
        d_bus = 4'b0000; cyc(2);
        go(11, 1, 0); cyc(2);
        for (int i = 0; i < 4; i++) begin
            set_ch(tab_c[i], tab_v[i]);
            cyc(3);
        end
        lit("mid_run_step4", 1, 0, 0, 0, 4, 2);
        reset = 1'b1; cyc(2);
        lit("mid_run_reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0; cyc(1);
        go(11, 1, 0); cyc(2);
        and_steps();
        lit("rerun_after_reset", 0, 1, 0, 0, 11, 0);

        // NUM_IN=4, DEPTH=8 build, non-strict, noise on other channels
        reset = 1'b1; cyc(2);
        act = 1'b1; d_bus = 4'b0000; cyc(1);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) prog(i, b_c[i], b_v[i]);
        go(8, 0, 0); cyc(2);
        for (int i = 0; i < 8; i++) begin
            int n;
            n = (b_c[i] + 1) % 4;
            d_bus[n] = ~d_bus[n]; cyc(1);
            d_bus[n] = ~d_bus[n]; cyc(1);
            set_ch(b_c[i], b_v[i]);
            cyc(3);
        end
        lit("b_build_done", 0, 1, 0, 0, 8, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
